debug_host_link: RTL and testbench

- Host-side counterpart of the debug unit's UART protocol.
- Serialises debug commands and program words into UART bytes for the MIPS debug unit.
- Reassembles the 7-byte reply frames the debug unit sends back into decoded words.
- Used as a bench driver and as the on-board host for self-test builds; connects to a uart instance's byte FIFO interface.

---
 rtl/debug_proto_pkg.sv | 32 +++
 rtl/debug_host_link_if.sv | 50 +++++
 rtl/debug_frame_rx.sv | 92 +++++++++
 rtl/debug_host_link.sv | 148 ++++++++++++++
 tb/tb_debug_host_link.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_proto_pkg.sv
// Shared protocol constants for the MIPS debug unit UART link.
// Latency: n/a (constants and type encodings only).
// Backpressure: n/a.
package debug_proto_pkg;

  // Reply frames are type, index, four data bytes and an XOR checksum.
  localparam int FRAME_BYTES = 7;

  // Host command bytes.
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  // Reply frame types.
  localparam logic [7:0] FT_REG = 8'h52;
  localparam logic [7:0] FT_MEM = 8'h4D;
  localparam logic [7:0] FT_PC  = 8'h50;
  localparam logic [7:0] FT_END = 8'h45;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_CMD  = 2'd1,
    TX_WAIT = 2'd2,
    TX_WORD = 2'd3
  } tx_state_t;

  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_COLLECT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/debug_host_link_if.sv
// Command, instruction, UART byte-FIFO and decoded-frame signals of the debug host link.
// Latency: n/a (wiring bundle).
// Backpressure: valid/ready on commands and words, FIFO full/empty on the UART side.
interface debug_host_link_if #(
  parameter int DATA_BITS = 8,
  parameter int WORD_SIZE = 32,
  parameter int MAX_WORDS = 64
);
  localparam int LEN_W = $clog2(MAX_WORDS + 1);

  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic [DATA_BITS-1:0] i_cmd;
  logic [LEN_W-1:0]     i_cmd_len;
  logic                 i_ins_valid;
  logic                 o_ins_ready;
  logic [WORD_SIZE-1:0] i_ins;
  logic                 o_uart_wr;
  logic [DATA_BITS-1:0] o_uart_data_wr;
  logic                 i_uart_tx_full;
  logic                 o_uart_rd;
  logic                 i_uart_rx_empty;
  logic [DATA_BITS-1:0] i_uart_data_rd;
  logic                 o_frame_valid;
  logic [DATA_BITS-1:0] o_frame_type;
  logic [DATA_BITS-1:0] o_frame_index;
  logic [WORD_SIZE-1:0] o_frame_data;
  logic                 o_frame_err;
  logic                 o_done;
  logic                 o_busy;

  // The link itself.
  modport slave (
    input  i_cmd_valid, i_cmd, i_cmd_len, i_ins_valid, i_ins,
           i_uart_tx_full, i_uart_rx_empty, i_uart_data_rd,
    output o_cmd_ready, o_ins_ready, o_uart_wr, o_uart_data_wr, o_uart_rd,
           o_frame_valid, o_frame_type, o_frame_index, o_frame_data,
           o_frame_err, o_done, o_busy
  );

  // Whoever drives commands and models the UART FIFOs.
  modport master (
    output i_cmd_valid, i_cmd, i_cmd_len, i_ins_valid, i_ins,
           i_uart_tx_full, i_uart_rx_empty, i_uart_data_rd,
    input  o_cmd_ready, o_ins_ready, o_uart_wr, o_uart_data_wr, o_uart_rd,
           o_frame_valid, o_frame_type, o_frame_index, o_frame_data,
           o_frame_err, o_done, o_busy
  );

endinterface

// File: rtl/debug_frame_rx.sv
// Reassembles 7-byte reply frames from the RX FIFO and checks the XOR checksum (DEBUG_HOST_TIMEOUT_EN adds a gap timeout).
// Latency: frame fields and o_frame_valid one cycle after the last byte is popped.
// Backpressure: none; pops every byte the FIFO presents, so the caller's pop is simply !empty.
module debug_frame_rx #(
  parameter int DATA_BITS      = 8,
  parameter int WORD_SIZE      = 32,
  parameter int FRAME_BYTES    = 7,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_pop,
  input  logic [DATA_BITS-1:0] i_byte,
  output logic                 o_frame_valid,
  output logic [DATA_BITS-1:0] o_frame_type,
  output logic [DATA_BITS-1:0] o_frame_index,
  output logic [WORD_SIZE-1:0] o_frame_data,
  output logic                 o_frame_err
);
  import debug_proto_pkg::*;

  localparam int SH_W  = (FRAME_BYTES - 1) * DATA_BITS;
  localparam int CNT_W = $clog2(FRAME_BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BYTES - 1);

  rx_state_t            rx_state;
  logic [CNT_W-1:0]     byte_cnt;
  logic [SH_W-1:0]      shreg;     // bytes 0..5, byte 0 ends up at the top
  logic [DATA_BITS-1:0] csum;      // running XOR of the bytes held so far

`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_cnt;
`endif

  // Shift bytes in, close the frame on the checksum byte, and optionally abandon a stalled partial frame.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_state      <= RX_IDLE;
      byte_cnt      <= '0;
      shreg         <= '0;
      csum          <= '0;
      o_frame_valid <= 1'b0;
      o_frame_type  <= '0;
      o_frame_index <= '0;
      o_frame_data  <= '0;
      o_frame_err   <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
      gap_cnt       <= '0;
`endif
    end else begin
      o_frame_valid <= 1'b0;
      if (i_pop) begin
`ifdef DEBUG_HOST_TIMEOUT_EN
        gap_cnt <= '0;
`endif
        if (byte_cnt == LAST) begin
          o_frame_valid <= 1'b1;
          o_frame_type  <= shreg[SH_W-1 -: DATA_BITS];
          o_frame_index <= shreg[SH_W-DATA_BITS-1 -: DATA_BITS];
          o_frame_data  <= shreg[WORD_SIZE-1:0];
          o_frame_err   <= (csum != i_byte);
          byte_cnt      <= '0;
          rx_state      <= RX_IDLE;
        end else begin
          shreg    <= {shreg[SH_W-DATA_BITS-1:0], i_byte};
          // First byte of a frame restarts the checksum instead of folding into the old one.
          csum     <= (rx_state == RX_IDLE) ? i_byte : (csum ^ i_byte);
          byte_cnt <= byte_cnt + 1'b1;
          rx_state <= RX_COLLECT;
        end
      end
`ifdef DEBUG_HOST_TIMEOUT_EN
      else if (rx_state == RX_COLLECT) begin
        if (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1)) begin
          o_frame_valid <= 1'b1;
          o_frame_err   <= 1'b1;
          o_frame_type  <= '0;
          o_frame_index <= '0;
          o_frame_data  <= '0;
          byte_cnt      <= '0;
          rx_state      <= RX_IDLE;
          gap_cnt       <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/debug_host_link.sv
// Host side of the debug UART link: serialises commands/program words and decodes reply frames (DEBUG_HOST_TIMEOUT_EN enables the RX gap timeout).
// Latency: a TX byte leaves the cycle it is pending and the FIFO is not full; frames appear one cycle after their last byte.
// Backpressure: TX stalls losslessly on i_uart_tx_full; commands held off by o_cmd_ready, words by o_ins_ready; RX never stalls.
module debug_host_link #(
  parameter int DATA_BITS      = 8,
  parameter int WORD_SIZE      = 32,
  parameter int FRAME_BYTES    = debug_proto_pkg::FRAME_BYTES,
  parameter int MAX_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  debug_host_link_if.slave bus
);
  import debug_proto_pkg::*;

  localparam int LEN_W      = $clog2(MAX_WORDS + 1);
  localparam int WORD_BYTES = WORD_SIZE / DATA_BITS;
  localparam int PTR_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORD_BYTES - 1);

  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] cmd_q;
  logic [LEN_W-1:0]     words_left;
  logic [WORD_SIZE-1:0] word_q;     // shifts left so the byte to send is always on top
  logic [PTR_W-1:0]     byte_ptr;
  logic                 cmd_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tx_pending;
  logic                 tx_fire;
  logic                 cmd_accept;

  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_type;
  logic [DATA_BITS-1:0] rx_index;
  logic [WORD_SIZE-1:0] rx_data;
  logic                 rx_err;

  assign tx_pending = (tx_state == TX_CMD) || (tx_state == TX_WORD);
  assign tx_fire    = tx_pending && !bus.i_uart_tx_full;
  assign cmd_accept = (tx_state == TX_IDLE) && bus.i_cmd_valid;

  assign bus.o_uart_wr      = tx_fire;
  assign bus.o_uart_data_wr = (tx_state == TX_CMD) ? cmd_q : word_q[WORD_SIZE-1 -: DATA_BITS];
  assign bus.o_ins_ready    = (tx_state == TX_WAIT) && bus.i_ins_valid;
  assign bus.o_cmd_ready    = cmd_ready_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;

  // TX sequencer: command byte, then for a load each word MSB first; a byte advances only when the FIFO takes it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_state    <= TX_IDLE;
      cmd_q       <= '0;
      words_left  <= '0;
      word_q      <= '0;
      byte_ptr    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.i_cmd_valid) begin
            cmd_q       <= bus.i_cmd;
            words_left  <= (bus.i_cmd_len > MAX_LEN) ? MAX_LEN : bus.i_cmd_len;
            tx_state    <= TX_CMD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        TX_CMD: begin
          if (tx_fire) begin
            if ((cmd_q == CMD_LOAD) && (words_left != '0)) begin
              tx_state <= TX_WAIT;
            end else begin
              tx_state    <= TX_IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        TX_WAIT: begin
          if (bus.i_ins_valid) begin
            word_q   <= bus.i_ins;
            byte_ptr <= '0;
            tx_state <= TX_WORD;
          end
        end
        TX_WORD: begin
          if (tx_fire) begin
            word_q   <= word_q << DATA_BITS;
            byte_ptr <= byte_ptr + 1'b1;
            if (byte_ptr == LAST_PTR) begin
              words_left <= words_left - 1'b1;
              if (words_left == LEN_W'(1)) begin
                tx_state    <= TX_IDLE;
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
              end else begin
                tx_state <= TX_WAIT;
              end
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Sticky end-of-program flag: a new command clears it, a clean END frame sets it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      done_q <= 1'b0;
    end else if (cmd_accept) begin
      done_q <= 1'b0;
    end else if (rx_valid && !rx_err && (rx_type == FT_END)) begin
      done_q <= 1'b1;
    end
  end

  assign bus.o_uart_rd = !bus.i_uart_rx_empty;

  debug_frame_rx #(
    .DATA_BITS      (DATA_BITS),
    .WORD_SIZE      (WORD_SIZE),
    .FRAME_BYTES    (FRAME_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pop         (!bus.i_uart_rx_empty),
    .i_byte        (bus.i_uart_data_rd),
    .o_frame_valid (rx_valid),
    .o_frame_type  (rx_type),
    .o_frame_index (rx_index),
    .o_frame_data  (rx_data),
    .o_frame_err   (rx_err)
  );

  assign bus.o_frame_valid = rx_valid;
  assign bus.o_frame_type  = rx_type;
  assign bus.o_frame_index = rx_index;
  assign bus.o_frame_data  = rx_data;
  assign bus.o_frame_err   = rx_err;

endmodule

// File: tb/tb_debug_host_link.sv
// Randomised self-checking bench for debug_host_link against a queue-based protocol model.
// Latency: n/a.
// Backpressure: TX FIFO full is randomised or held for fixed stalls; RX bytes arrive with random gaps.
module tb_debug_host_link;

  localparam int DATA_BITS = 8;
  localparam int WORD_SIZE = 32;
  localparam int MAX_WORDS = 64;
  localparam int LEN_W     = $clog2(MAX_WORDS + 1);
`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 100000;
`endif

  typedef struct packed {
    logic [7:0]  ft;
    logic [7:0]  idx;
    logic [31:0] dat;
    logic        err;
    logic        tmo;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_host_link_if #(.DATA_BITS(DATA_BITS), .WORD_SIZE(WORD_SIZE), .MAX_WORDS(MAX_WORDS)) bus ();

  debug_host_link #(
    .DATA_BITS      (DATA_BITS),
    .WORD_SIZE      (WORD_SIZE),
    .FRAME_BYTES    (7),
    .MAX_WORDS      (MAX_WORDS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- TX side: FIFO full driver and byte capture ----------------
  logic [7:0]  tx_got[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] fixed_w[$];
  int stall_at  = -1;
  int stall_cnt = 0;
  bit rand_full = 1'b0;

  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      bus.i_uart_tx_full = 1'b1;
      stall_cnt--;
    end else begin
      bus.i_uart_tx_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.o_uart_wr) begin
      check("wr_while_full", bus.i_uart_tx_full, 0);
      tx_got.push_back(bus.o_uart_data_wr);
      if (tx_got.size() == stall_at) begin
        stall_cnt = 5;
        stall_at  = -1;
      end
    end
  end

  // ---------------- RX side: FWFT FIFO model and frame scoreboard ----------------
  logic [7:0] rx_q[$];
  bit     rx_present = 1'b0;
  int     last_pop   = 0;
  frame_t exp_fr[$];
  frame_t mon_e;

  always @(posedge clk) begin
    #1;
    if (rx_present) begin
      rx_q.delete(0);
      last_pop = cyc;
    end
    if (rx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      bus.i_uart_data_rd  = rx_q[0];
      bus.i_uart_rx_empty = 1'b0;
      rx_present          = 1'b1;
    end else begin
      bus.i_uart_data_rd  = 8'($urandom);
      bus.i_uart_rx_empty = 1'b1;
      rx_present          = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("uart_rd", bus.o_uart_rd, !bus.i_uart_rx_empty);
      if (bus.o_frame_valid) begin
        if (exp_fr.size() == 0) begin
          check("frame_extra", 1, 0);
        end else begin
          mon_e = exp_fr.pop_front();
          check("frame_type", bus.o_frame_type, mon_e.ft);
          check("frame_index", bus.o_frame_index, mon_e.idx);
          check("frame_data", bus.o_frame_data, mon_e.dat);
          check("frame_err", bus.o_frame_err, mon_e.err);
          if (mon_e.tmo) check("timeout_cycle", cyc - last_pop, TMO);
        end
      end
    end
  end

  function automatic logic [55:0] good_frame(input logic [47:0] h);
    return {h, h[47:40] ^ h[39:32] ^ h[31:24] ^ h[23:16] ^ h[15:8] ^ h[7:0]};
  endfunction

  task automatic send_frame(input logic [55:0] f);
    frame_t e;
    for (int i = 6; i >= 0; i--) rx_q.push_back(f[i*8 +: 8]);
    e.ft  = f[55:48];
    e.idx = f[47:40];
    e.dat = f[39:8];
    e.err = ((f[55:48] ^ f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8]) != f[7:0]);
    e.tmo = 1'b0;
    exp_fr.push_back(e);
  endtask

  task automatic wait_rx();
    int k = 0;
    while ((rx_q.size() != 0 || rx_present) && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) check("rx_drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  // ---------------- command driver with expected byte stream ----------------
  task automatic run_cmd(input logic [7:0] cmd, input int len, input int stall);
    int n;
    int k;
    bit acc;
    logic [31:0] w[$];
    n = (cmd == 8'h4C) ? ((len > MAX_WORDS) ? MAX_WORDS : len) : 0;
    tx_got.delete();
    exp_tx.delete();
    exp_tx.push_back(cmd);
    for (int i = 0; i < n; i++) begin
      w.push_back((i < fixed_w.size()) ? fixed_w[i] : $urandom);
      for (int b = 3; b >= 0; b--) exp_tx.push_back(w[i][b*8 +: 8]);
    end
    stall_at = stall;
    k = 0;
    while (!bus.o_cmd_ready && k < 1000) begin
      tick();
      k++;
    end
    check("cmd_ready", bus.o_cmd_ready, 1);
    bus.i_cmd       = cmd;
    bus.i_cmd_len   = LEN_W'(len);
    bus.i_cmd_valid = 1'b1;
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = 8'($urandom);
    bus.i_cmd_len   = LEN_W'($urandom);
    check("busy_set", bus.o_busy, 1);
    for (int i = 0; i < n; i++) begin
      bus.i_ins = w[i];
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 2000) begin
        bus.i_ins_valid = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        acc = bus.i_ins_valid && bus.o_ins_ready;
        tick();
        k++;
      end
      if (!acc) begin
        check("ins_accept_timeout", 0, 1);
        break;
      end
    end
    bus.i_ins_valid = 1'b0;
    k = 0;
    while (bus.o_busy && k < 3000) begin
      tick();
      k++;
    end
    check("busy_clear", bus.o_busy, 0);
    repeat (2) tick();
    check("tx_count", tx_got.size(), exp_tx.size());
    for (int i = 0; i < tx_got.size() && i < exp_tx.size(); i++)
      check("tx_byte", tx_got[i], exp_tx[i]);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    check("rst_busy", bus.o_busy, 0);
    check("rst_uart_wr", bus.o_uart_wr, 0);
    check("rst_ins_ready", bus.o_ins_ready, 0);
    check("rst_frame_valid", bus.o_frame_valid, 0);
    check("rst_frame_err", bus.o_frame_err, 0);
    check("rst_frame_type", bus.o_frame_type, 0);
    check("rst_frame_data", bus.o_frame_data, 0);
    check("rst_done", bus.o_done, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] f;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = '0;
    bus.i_cmd_len   = '0;
    bus.i_ins_valid = 1'b0;
    bus.i_ins       = '0;
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Directed load, then the same load with a 5-cycle FIFO stall after byte 3.
    fixed_w.push_back(32'h20010005);
    fixed_w.push_back(32'h00000000);
    run_cmd(8'h4C, 2, -1);
    run_cmd(8'h4C, 2, 3);
    fixed_w.delete();

    // Randomised FIFO backpressure over varied commands and lengths.
    rand_full = 1'b1;
    run_cmd(8'h43, 5, -1);
    run_cmd(8'h4C, 0, -1);
    run_cmd(8'h53, 0, -1);
    for (int r = 0; r < 4; r++) run_cmd(8'h4C, $urandom_range(1, 8), -1);
    run_cmd(8'($urandom), $urandom_range(0, 3), -1);
    run_cmd(8'h4C, 100, -1);
    check("clamp_bytes", tx_got.size(), 1 + 4 * MAX_WORDS);
    rand_full = 1'b0;

    // Directed reply frames and the done flag.
    send_frame(56'h52_03_00_00_00_2A_7B);
    send_frame(56'h52_03_00_00_00_2A_7C);
    wait_rx();
    send_frame(56'h45_00_00_00_00_00_44);
    wait_rx();
    check("done_bad_end", bus.o_done, 0);
    send_frame(56'h45_00_00_00_00_00_45);
    wait_rx();
    check("done_set", bus.o_done, 1);
    run_cmd(8'h43, 0, -1);
    check("done_cleared", bus.o_done, 0);

    // Random frames, mixed good and bad checksums.
    for (int r = 0; r < 12; r++) begin
      f = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) f = good_frame(f[55:8]);
      send_frame(f);
    end
    wait_rx();

    // TX and RX running at the same time.
    rand_full = 1'b1;
    fork
      run_cmd(8'h4C, 6, -1);
      begin
        for (int r = 0; r < 3; r++) send_frame(good_frame({$urandom, 16'($urandom)}));
        wait_rx();
      end
    join
    rand_full = 1'b0;

    // Reset in the middle of a frame discards the partial bytes.
    rx_q.push_back(8'h52);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    wait_rx();
    rst_n = 1'b0;
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    send_frame(good_frame(48'h4D_07_DE_AD_BE_EF));
    wait_rx();

`ifdef DEBUG_HOST_TIMEOUT_EN
    begin
      frame_t e;
      e = '0;
      e.err = 1'b1;
      e.tmo = 1'b1;
      exp_fr.push_back(e);
      for (int i = 0; i < 4; i++) rx_q.push_back(8'($urandom));
      wait_rx();
      repeat (TMO + 10) tick();
      send_frame(good_frame(48'h50_00_00_40_00_10));
      wait_rx();
    end
`endif

    check("frames_missing", exp_fr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
